// File: rtl/forthsuper_pkg.sv
// Shared forthsuper definitions: stack command encoding and the bit
// positions used in the sequencer's err pulse.
package forthsuper_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        PUSH = 3'd1,
        DROP = 3'd2,
        DUP  = 3'd3,
        SWAP = 3'd4,
        OVER = 3'd5,
        ROT  = 3'd6
    } ss_cmd_t;

    localparam int SS_UNF = 0;
    localparam int SS_OVF = 1;

endpackage

// File: rtl/stack_seq.sv
// stack_seq: Forth data-stack sequencer. T and N live in registers; deeper
// entries spill to / fill from an external single-port stack RAM.
// Optional feature: define SS_ROT_EN to implement ROT (adds the ROTW state);
// without it ROT is rejected with an underflow pulse.
module stack_seq
    import forthsuper_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int SSZ   = $clog2(DEPTH),
    parameter int DSW   = $clog2(DEPTH + 3)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  ss_cmd_t         cmd_op,
    input  logic [DSZ-1:0]  cmd_vi,
    output logic [DSZ-1:0]  tos,
    output logic [DSZ-1:0]  nos,
    output logic [DSW-1:0]  depth,
    output logic [1:0]      err,
    output logic            mem_we,
    output logic [SSZ-1:0]  mem_addr,
    output logic [DSZ-1:0]  mem_wd,
    input  logic [DSZ-1:0]  mem_rd
);

`ifdef SS_ROT_EN
    typedef enum logic [1:0] {IDLE, FILL, ROTW} state_t;
`else
    typedef enum logic [1:0] {IDLE, FILL} state_t;
`endif

    localparam logic [DSW-1:0] D_TWO   = DSW'(2);
    localparam logic [DSW-1:0] D_THREE = DSW'(3);
    localparam logic [DSW-1:0] D_FULL  = DSW'(DEPTH + 2);

    state_t         state;
    logic [SSZ-1:0] msp;
    logic [SSZ-1:0] mtop;
    logic           unf;
    logic           ovf;
    logic           full;
    logic           empty;

    assign cmd_rdy = (state == IDLE);
    assign full    = (depth == D_FULL);
    assign empty   = (depth == '0);

    // RAM-resident entry count and the address of the topmost RAM entry
    always_comb begin
        msp  = (depth >= D_TWO) ? SSZ'(depth - D_TWO) : '0;
        mtop = msp - 1'b1;
    end

    // Legality of the presented command against the current depth
    always_comb begin
        unf = 1'b0;
        ovf = 1'b0;
        case (cmd_op)
            PUSH: ovf = full;
            DUP:  begin unf = empty; ovf = full; end
            OVER: begin unf = (depth < D_TWO); ovf = full; end
            DROP: unf = empty;
            SWAP: unf = (depth < D_TWO);
`ifdef SS_ROT_EN
            ROT:  unf = (depth < D_THREE);
`else
            ROT:  unf = 1'b1;
`endif
            default: ;
        endcase
    end

    // Sequencer FSM with registered stack cache and RAM strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tos      <= '0;
            nos      <= '0;
            depth    <= '0;
            err      <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            err    <= '0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_vld) begin
                        if (unf || ovf) begin
                            err[SS_UNF] <= unf;
                            err[SS_OVF] <= ovf;
                        end else begin
                            case (cmd_op)
                                PUSH, DUP, OVER: begin
                                    if (depth >= D_TWO) begin
                                        mem_we   <= 1'b1;
                                        mem_addr <= msp;
                                        mem_wd   <= nos;
                                    end
                                    depth <= depth + 1'b1;
                                    nos   <= tos;
                                    if (cmd_op == PUSH)
                                        tos <= cmd_vi;
                                    else if (cmd_op == OVER)
                                        tos <= nos;
                                end
                                SWAP: begin
                                    tos <= nos;
                                    nos <= tos;
                                end
                                DROP: begin
                                    tos   <= nos;
                                    depth <= depth - 1'b1;
                                    if (depth > D_TWO) begin
                                        mem_addr <= mtop;
                                        state    <= FILL;
                                    end else begin
                                        nos <= '0;
                                    end
                                end
`ifdef SS_ROT_EN
                                // Read of a and write of b share one address in
                                // ROTW; the RAM returns the old word (read-before-write).
                                ROT: begin
                                    nos      <= tos;
                                    mem_we   <= 1'b1;
                                    mem_addr <= mtop;
                                    mem_wd   <= nos;
                                    state    <= ROTW;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                FILL: begin
                    nos   <= mem_rd;
                    state <= IDLE;
                end
`ifdef SS_ROT_EN
                ROTW: begin
                    tos   <= mem_rd;
                    state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// Directed testbench for stack_seq with a behavioural stack RAM.
module tb_stack_seq;
    import forthsuper_pkg::*;

    localparam int DEPTH = 64;
    localparam int DSZ   = 32;
    localparam int SSZ   = 6;
    localparam int DSW   = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_vld;
    logic           cmd_rdy;
    ss_cmd_t        cmd_op;
    logic [DSZ-1:0] cmd_vi;
    logic [DSZ-1:0] tos;
    logic [DSZ-1:0] nos;
    logic [DSW-1:0] depth;
    logic [1:0]     err;
    logic           mem_we;
    logic [SSZ-1:0] mem_addr;
    logic [DSZ-1:0] mem_wd;
    logic [DSZ-1:0] mem_rd;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int w0;

    logic [DSZ-1:0] ram [DEPTH];

    always #5 clk = ~clk;

    stack_seq #(.DEPTH(DEPTH), .DSZ(DSZ), .SSZ(SSZ), .DSW(DSW)) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_op(cmd_op), .cmd_vi(cmd_vi), .tos(tos), .nos(nos),
        .depth(depth), .err(err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Single-port RAM, read-before-write, read data follows the address
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wd;
            wr_cnt        <= wr_cnt + 1;
        end
    end
    assign mem_rd = ram[mem_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and return 1 time unit after the accepting edge
    task automatic issue(input ss_cmd_t op, input logic [DSZ-1:0] v);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) check("rdy_timeout", 64'(cmd_rdy), 64'd1);
        cmd_vld = 1'b1;
        cmd_op  = op;
        cmd_vi  = v;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
        cmd_op  = NOP;
        cmd_vi  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tos"},   64'(tos),      64'd0);
        check({tag, "_nos"},   64'(nos),      64'd0);
        check({tag, "_depth"}, 64'(depth),    64'd0);
        check({tag, "_err"},   64'(err),      64'd0);
        check({tag, "_we"},    64'(mem_we),   64'd0);
        check({tag, "_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_wd"},    64'(mem_wd),   64'd0);
        check({tag, "_rdy"},   64'(cmd_rdy),  64'd1);
    endtask

    task automatic push123();
        issue(PUSH, 1);
        issue(PUSH, 2);
        issue(PUSH, 3);
    endtask

    initial begin
        rst     = 1'b1;
        cmd_vld = 1'b0;
        cmd_op  = NOP;
        cmd_vi  = '0;
        #1 rst = 1'b0;
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b1;

        // PUSH 1,2,3 back to back
        issue(PUSH, 1);
        check("p1_rdy", 64'(cmd_rdy), 64'd1);
        check("p1_tos", 64'(tos), 64'd1);
        issue(PUSH, 2);
        check("p2_rdy", 64'(cmd_rdy), 64'd1);
        check("p2_we", 64'(mem_we), 64'd0);
        issue(PUSH, 3);
        check("p3_rdy", 64'(cmd_rdy), 64'd1);
        check("p3_tos", 64'(tos), 64'd3);
        check("p3_nos", 64'(nos), 64'd2);
        check("p3_depth", 64'(depth), 64'd3);
        check("p3_we", 64'(mem_we), 64'd1);
        check("p3_addr", 64'(mem_addr), 64'd0);
        check("p3_wd", 64'(mem_wd), 64'd1);
        tick();
        check("p3_ram0", 64'(ram[0]), 64'd1);
        check("p3_wrcnt", 64'(wr_cnt), 64'd1);
        check("p3_we_off", 64'(mem_we), 64'd0);

        // DROP with fill, then DROP without
        issue(DROP, 0);
        check("d1_tos", 64'(tos), 64'd2);
        check("d1_depth", 64'(depth), 64'd2);
        check("d1_rdy", 64'(cmd_rdy), 64'd0);
        tick();
        check("d1_nos", 64'(nos), 64'd1);
        check("d1_rdy2", 64'(cmd_rdy), 64'd1);
        issue(DROP, 0);
        check("d2_tos", 64'(tos), 64'd1);
        check("d2_nos", 64'(nos), 64'd0);
        check("d2_depth", 64'(depth), 64'd1);
        check("d2_rdy", 64'(cmd_rdy), 64'd1);

        // ROT from 1 2 3
        do_reset();
        push123();
`ifdef SS_ROT_EN
        issue(ROT, 0);
        check("r1_rdy", 64'(cmd_rdy), 64'd0);
        check("r1_we", 64'(mem_we), 64'd1);
        check("r1_wd", 64'(mem_wd), 64'd2);
        tick();
        check("r1_tos", 64'(tos), 64'd1);
        check("r1_nos", 64'(nos), 64'd3);
        check("r1_depth", 64'(depth), 64'd3);
        check("r1_ram0", 64'(ram[0]), 64'd2);
        check("r1_rdy2", 64'(cmd_rdy), 64'd1);
        issue(ROT, 0);
        tick();
        check("r2_tos", 64'(tos), 64'd2);
        check("r2_nos", 64'(nos), 64'd1);
        check("r2_ram0", 64'(ram[0]), 64'd3);
        issue(DROP, 0);
        tick();
        issue(ROT, 0);
        check("r_unf_err", 64'(err), 64'd1);
        check("r_unf_depth", 64'(depth), 64'd2);
`else
        issue(ROT, 0);
        check("r1_err", 64'(err), 64'd1);
        check("r1_tos", 64'(tos), 64'd3);
        check("r1_nos", 64'(nos), 64'd2);
        check("r1_depth", 64'(depth), 64'd3);
        check("r1_rdy", 64'(cmd_rdy), 64'd1);
        tick();
        check("r1_err_clr", 64'(err), 64'd0);
`endif

        // SWAP / OVER / DUP from 5 7
        do_reset();
        issue(PUSH, 5);
        issue(PUSH, 7);
        issue(SWAP, 0);
        check("sw_tos", 64'(tos), 64'd5);
        check("sw_nos", 64'(nos), 64'd7);
        check("sw_we", 64'(mem_we), 64'd0);
        issue(OVER, 0);
        check("ov_tos", 64'(tos), 64'd7);
        check("ov_nos", 64'(nos), 64'd5);
        check("ov_depth", 64'(depth), 64'd3);
        issue(DUP, 0);
        check("dup_ram0", 64'(ram[0]), 64'd7);
        check("dup_tos", 64'(tos), 64'd7);
        check("dup_nos", 64'(nos), 64'd7);
        check("dup_depth", 64'(depth), 64'd4);
        tick();
        check("dup_ram1", 64'(ram[1]), 64'd5);

        // Underflow cases at low depth
        do_reset();
        issue(DROP, 0);
        check("unf_drop_err", 64'(err), 64'd1);
        check("unf_drop_depth", 64'(depth), 64'd0);
        issue(DUP, 0);
        check("unf_dup_err", 64'(err), 64'd1);
        issue(PUSH, 4);
        check("unf_push_err", 64'(err), 64'd0);
        issue(SWAP, 0);
        check("unf_swap_err", 64'(err), 64'd1);
        check("unf_swap_tos", 64'(tos), 64'd4);
        issue(OVER, 0);
        check("unf_over_err", 64'(err), 64'd1);
        check("unf_over_depth", 64'(depth), 64'd1);

        // Fill to DEPTH+2, then overflow
        do_reset();
        for (int i = 1; i <= DEPTH + 2; i++) issue(PUSH, DSZ'(i));
        check("full_depth", 64'(depth), 64'(DEPTH + 2));
        check("full_tos", 64'(tos), 64'(DEPTH + 2));
        check("full_nos", 64'(nos), 64'(DEPTH + 1));
        tick();
        w0 = wr_cnt;
        issue(PUSH, 99);
        check("ovf_err", 64'(err), 64'd2);
        check("ovf_depth", 64'(depth), 64'(DEPTH + 2));
        check("ovf_tos", 64'(tos), 64'(DEPTH + 2));
        check("ovf_we", 64'(mem_we), 64'd0);
        tick();
        check("ovf_err_clr", 64'(err), 64'd0);
        check("ovf_wrcnt", 64'(wr_cnt), 64'(w0));
        check("full_ram63", 64'(ram[63]), 64'(DEPTH));
        check("full_ram0", 64'(ram[0]), 64'd1);
        issue(DROP, 0);
        check("fd_tos", 64'(tos), 64'(DEPTH + 1));
        tick();
        check("fd_nos", 64'(nos), 64'(DEPTH));
        check("fd_depth", 64'(depth), 64'(DEPTH + 1));

        // Reset asserted during FILL
        do_reset();
        push123();
        issue(DROP, 0);
        check("mf_rdy", 64'(cmd_rdy), 64'd0);
        rst = 1'b0;
        #1;
        check_reset_vals("mf");
        @(negedge clk);
        rst = 1'b1;
        issue(PUSH, 9);
        check("mf_tos", 64'(tos), 64'd9);
        check("mf_nos", 64'(nos), 64'd0);
        check("mf_depth", 64'(depth), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
